vga_line_fetch: RTL and testbench

Ping-pong line buffer that feeds pixel data to the VGA timing controller. It prefetches whole display lines from an upstream frame-store read port through a request/acknowledge plus pixel-stream handshake, and holds them in two line banks. It answers each `vga_request`/`vga_xpos`/`vga_ypos` with registered `vga_data` one clock later. It also flags underruns when a line is not resident in time.

---
 rtl/vga_line_fetch.sv | 110 +++++++++++
 tb/tb_vga_line_fetch.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: ping-pong line buffer prefetching display lines from a frame store
// and serving registered pixels to the VGA timing controller, with underrun flagging.
module vga_line_fetch #(
  parameter int H_DISP = 640,
  parameter int V_DISP = 480,
  parameter int DW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vga_request,
  input  logic [10:0]   vga_xpos,
  input  logic [10:0]   vga_ypos,
  input  logic          vga_framesync,
  output logic [DW-1:0] vga_data,
  output logic          mem_line_req,
  output logic [10:0]   mem_line_idx,
  input  logic          mem_line_ack,
  input  logic          mem_pix_valid,
  input  logic [DW-1:0] mem_pix_data,
  output logic          underrun
);
  localparam int AW = $clog2(H_DISP);
  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
  state_t state_q, state_d;
  logic [1:0] full_q, full_d;
  logic [1:0][10:0] tag_q, tag_d;
  logic [10:0] next_row_q, next_row_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic pend_q, pend_d, fs_q, underrun_q, underrun_d, hit_q, hit_d;
  logic [DW-1:0] mem [2][H_DISP];
  logic [DW-1:0] rd_q;
  logic [10:0] row;
  logic rb, fall, wr_en;
  always_comb begin
    row = vga_ypos - 11'd1;
    rb = row[0];
    hit_d = vga_request && full_q[rb] && tag_q[rb] == row;
    fall = fs_q && !vga_framesync;
    wr_en = state_q == FILL && mem_pix_valid;
    state_d = state_q;
    full_d = full_q;
    tag_d = tag_q;
    next_row_d = next_row_q;
    waddr_d = waddr_q;
    pend_d = pend_q | fall;
    underrun_d = fall ? 1'b0 : underrun_q | (vga_request && !hit_d);
    if (hit_d && vga_xpos == 11'(H_DISP - 1)) full_d[rb] = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          full_d = 2'b00;
          next_row_d = '0;
          pend_d = fall;
        end else if (next_row_q < 11'(V_DISP) && !full_q[next_row_q[0]]) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_line_ack) begin
          state_d = FILL;
          waddr_d = '0;
        end
      end
      FILL: begin
        if (mem_pix_valid) waddr_d = waddr_q + 1'b1;
        // a resync seen during the fill discards this line instead of publishing it
        if (mem_pix_valid && waddr_q == AW'(H_DISP - 1)) begin
          state_d = IDLE;
          if (!pend_q) begin
            full_d[next_row_q[0]] = 1'b1;
            tag_d[next_row_q[0]] = next_row_q;
            next_row_d = next_row_q + 11'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      full_q <= 2'b00;
      tag_q <= '0;
      next_row_q <= '0;
      waddr_q <= '0;
      pend_q <= 1'b0;
      fs_q <= 1'b1;
      underrun_q <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q <= full_d;
      tag_q <= tag_d;
      next_row_q <= next_row_d;
      waddr_q <= waddr_d;
      pend_q <= pend_d;
      fs_q <= vga_framesync;
      underrun_q <= underrun_d;
      hit_q <= hit_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[next_row_q[0]][waddr_q] <= mem_pix_data;
    rd_q <= mem[rb][vga_xpos[AW-1:0]];
  end
  assign vga_data = hit_q ? rd_q : '0;
  assign mem_line_req = state_q == REQ;
  assign mem_line_idx = next_row_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: randomized frame-store model driving vga_line_fetch, with
// expected pixels computed from a row/column hash.
module tb_vga_line_fetch;
  localparam int H = 16, V = 12, DW = 16;
  logic clk = 0, rst_n = 0, vga_request = 0, vga_framesync = 1;
  logic mem_line_ack = 0, mem_pix_valid = 0;
  logic [10:0] vga_xpos = 0, vga_ypos = 0;
  logic [DW-1:0] mem_pix_data = 0;
  logic [DW-1:0] vga_data;
  logic mem_line_req, underrun;
  logic [10:0] mem_line_idx;
  int tests = 0, fails = 0;
  int ack_lat = 0, gap_pct = 0, salt = 0;
  int fetched[$];
  int done_rows = 0, cur_row = -1, cur_beats = 0, prow = 0;

  vga_line_fetch #(.H_DISP(H), .V_DISP(V), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .vga_request(vga_request), .vga_xpos(vga_xpos),
    .vga_ypos(vga_ypos), .vga_framesync(vga_framesync), .vga_data(vga_data),
    .mem_line_req(mem_line_req), .mem_line_idx(mem_line_idx), .mem_line_ack(mem_line_ack),
    .mem_pix_valid(mem_pix_valid), .mem_pix_data(mem_pix_data), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pix(int r, int c, int s);
    return DW'(r * 97 + c * 13 + s * 1009 + 1);
  endfunction

  // frame-store model: acks after ack_lat cycles, streams H beats with random gaps
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mem_line_req) begin
        prow = int'(mem_line_idx);
        fetched.push_back(prow);
        for (int i = 0; i < ack_lat && rst_n; i++) begin
          @(negedge clk);
          if (rst_n) begin
            tests++;
            if (mem_line_req !== 1'b1 || mem_line_idx !== 11'(prow)) begin
              fails++;
              $display("FAIL handshake_hold req=%b idx=%0d expected req=1 idx=%0d", mem_line_req, mem_line_idx, prow);
            end
          end
        end
        if (rst_n) begin
          mem_line_ack = 1;
          @(negedge clk);
          mem_line_ack = 0;
          if (rst_n) begin
            tests++;
            if (mem_line_req !== 1'b0) begin
              fails++;
              $display("FAIL req_drop req=%b expected 0", mem_line_req);
            end
            cur_row = prow;
            cur_beats = 0;
            while (cur_beats < H && rst_n) begin
              if ($urandom_range(99) < gap_pct) mem_pix_valid = 0;
              else begin
                mem_pix_valid = 1;
                mem_pix_data = pix(prow, cur_beats, salt);
                cur_beats++;
              end
              @(negedge clk);
            end
            mem_pix_valid = 0;
            if (cur_beats == H) done_rows++;
            cur_row = -1;
          end
        end
      end
    end
  end

  task automatic wait_done(input int n, output bit ok);
    int c = 0;
    while (done_rows < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    ok = done_rows >= n;
  endtask

  task automatic read_line(input int r, output logic [DW-1:0] got [H], output int xs [H],
                           output logic [DW-1:0] idle);
    for (int i = 0; i < H; i++) begin
      @(negedge clk);
      if (i > 0) got[i-1] = vga_data;
      xs[i] = (i == H - 1) ? H - 1 : int'($urandom_range(H - 2, 0));
      vga_request = 1;
      vga_xpos = 11'(xs[i]);
      vga_ypos = 11'(r + 1);
    end
    @(negedge clk);
    got[H-1] = vga_data;
    vga_request = 0;
    @(negedge clk);
    idle = vga_data;
  endtask

  task automatic test_reset;
    int c = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    while (!(cur_row == 0 && cur_beats >= 5) && c < 200) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (!(cur_row == 0 && cur_beats >= 5)) begin
      fails++;
      $display("FAIL reset_prefill row=%0d beats=%0d expected row 0 mid-fill", cur_row, cur_beats);
    end
    rst_n = 0;
    #1;
    tests++;
    if ({vga_data, mem_line_req, mem_line_idx, underrun} !== '0) begin
      fails++;
      $display("FAIL reset_outputs data=%h req=%b idx=%0d urun=%b expected all 0", vga_data, mem_line_req, mem_line_idx, underrun);
    end
    repeat (3) @(negedge clk);
    fetched.delete();
    rst_n = 1;
    c = 0;
    while (!mem_line_req && c < 5) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (mem_line_req !== 1'b1 || c < 1 || c > 2 || mem_line_idx !== 11'd0) begin
      fails++;
      $display("FAIL reset_first_req req=%b cycles=%0d idx=%0d expected req=1 within 1..2 cycles idx=0", mem_line_req, c, mem_line_idx);
    end
  endtask

  task automatic test_fill_read;
    bit ok;
    logic [DW-1:0] got [H];
    int xs [H];
    logic [DW-1:0] idle;
    wait_done(2, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL fill_timeout done=%0d expected 2", done_rows);
    end
    read_line(0, got, xs, idle);
    for (int i = 0; i < H; i++) begin
      tests++;
      if (got[i] !== pix(0, xs[i], salt)) begin
        fails++;
        $display("FAIL fill_read x=%0d got=%h expected %h", xs[i], got[i], pix(0, xs[i], salt));
      end
    end
    tests++;
    if (idle !== '0 || underrun !== 1'b0) begin
      fails++;
      $display("FAIL fill_idle data=%h urun=%b expected 0 0", idle, underrun);
    end
  endtask

  task automatic test_handshake;
    bit ok;
    logic [DW-1:0] got [H];
    int xs [H];
    logic [DW-1:0] idle;
    ack_lat = 7;
    gap_pct = 40;
    read_line(1, got, xs, idle);
    for (int i = 0; i < H; i++) begin
      tests++;
      if (got[i] !== pix(1, xs[i], salt)) begin
        fails++;
        $display("FAIL hs_row1 x=%0d got=%h expected %h", xs[i], got[i], pix(1, xs[i], salt));
      end
    end
    wait_done(4, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL hs_timeout done=%0d expected 4", done_rows);
    end
    for (int r = 2; r < 4; r++) begin
      read_line(r, got, xs, idle);
      for (int i = 0; i < H; i++) begin
        tests++;
        if (got[i] !== pix(r, xs[i], salt)) begin
          fails++;
          $display("FAIL hs_read row=%0d x=%0d got=%h expected %h", r, xs[i], got[i], pix(r, xs[i], salt));
        end
      end
    end
    tests++;
    if (underrun !== 1'b0) begin
      fails++;
      $display("FAIL hs_underrun got=%b expected 0", underrun);
    end
  endtask

  task automatic test_underrun;
    int bad = 0;
    @(negedge clk);
    vga_request = 1;
    vga_xpos = 11'd3;
    vga_ypos = 11'd7;
    @(negedge clk);
    vga_request = 0;
    tests++;
    if (vga_data !== '0 || underrun !== 1'b1) begin
      fails++;
      $display("FAIL underrun_set data=%h urun=%b expected 0 1", vga_data, underrun);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (underrun !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL underrun_sticky drops=%0d expected 0", bad);
    end
    vga_framesync = 0;
    @(negedge clk);
    tests++;
    if (underrun !== 1'b0) begin
      fails++;
      $display("FAIL underrun_clear got=%b expected 0", underrun);
    end
  endtask

  task automatic test_ping_pong;
    bit ok;
    int base, bad = 0, reqs = 0;
    logic [DW-1:0] got [H];
    int xs [H];
    logic [DW-1:0] idle;
    repeat (300) @(negedge clk);
    salt = 1;
    ack_lat = 3;
    gap_pct = 0;
    vga_framesync = 1;
    repeat (2) @(negedge clk);
    base = done_rows;
    fetched.delete();
    vga_framesync = 0;
    wait_done(base + 2, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL pp_prefetch done=%0d expected %0d", done_rows, base + 2);
    end
    for (int r = 0; r < V; r++) begin
      read_line(r, got, xs, idle);
      for (int i = 0; i < H; i++) if (got[i] !== pix(r, xs[i], salt)) bad++;
      repeat (14) @(negedge clk);
    end
    tests++;
    if (bad != 0 || underrun !== 1'b0) begin
      fails++;
      $display("FAIL pp_frame bad_pixels=%0d urun=%b expected 0 0", bad, underrun);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_line_req) reqs++;
    end
    tests++;
    if (reqs != 0) begin
      fails++;
      $display("FAIL pp_idle req_cycles=%0d expected 0", reqs);
    end
    bad = 0;
    for (int i = 0; i < fetched.size(); i++) if (fetched[i] != i) bad++;
    tests++;
    if (fetched.size() != V || bad != 0) begin
      fails++;
      $display("FAIL pp_order fetched=%0d out_of_order=%0d expected %0d 0", fetched.size(), bad, V);
    end
  endtask

  task automatic test_resync_fill;
    bit ok;
    int base, c = 0, n0, bad = 0;
    logic [DW-1:0] got [H];
    int xs [H];
    logic [DW-1:0] idle;
    salt = 2;
    ack_lat = 2;
    gap_pct = 50;
    vga_framesync = 1;
    repeat (2) @(negedge clk);
    base = done_rows;
    vga_framesync = 0;
    repeat (2) @(negedge clk);
    vga_framesync = 1;
    wait_done(base + 2, ok);
    for (int r = 0; r < 4; r++) read_line(r, got, xs, idle);
    while (!(cur_row == 5 && cur_beats >= 3) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (!(cur_row == 5 && cur_beats >= 3)) begin
      fails++;
      $display("FAIL rs_row5_start row=%0d beats=%0d expected row 5 mid-fill", cur_row, cur_beats);
    end
    n0 = fetched.size();
    vga_framesync = 0;
    vga_request = 1;
    vga_xpos = 11'd0;
    vga_ypos = 11'd6;
    @(negedge clk);
    c = 0;
    while (fetched.size() == n0 && c < 500) begin
      @(negedge clk);
      if (vga_data !== '0) bad++;
      c++;
    end
    vga_request = 0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rs_row5_discard nonzero_cycles=%0d expected 0", bad);
    end
    tests++;
    if (fetched.size() <= n0 || fetched[n0] != 0) begin
      fails++;
      $display("FAIL rs_next_idx got=%0d expected 0", fetched.size() > n0 ? fetched[n0] : -1);
    end
    wait_done(done_rows + 1, ok);
    read_line(0, got, xs, idle);
    bad = 0;
    for (int i = 0; i < H; i++) if (got[i] !== pix(0, xs[i], salt)) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rs_row0_read bad_pixels=%0d expected 0", bad);
    end
  endtask

  initial begin
    test_reset;
    test_fill_read;
    test_handshake;
    test_underrun;
    test_ping_pong;
    test_resync_fill;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
